rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between two writeback sources:
//  port 0 = in-order pipeline WB stage, port 1 = long-latency unit (load miss / mul-div).
//  Fixed priority to port 0 with anti-starvation promotion of port 1; registered outputs.
//  Sits between the WB stage and register_file; the file writes on negedge of the output cycle.
// PARAMETERS
//  XLEN        32  data width of a writeback
//  REG_AW      5   register address width (32 architectural regs)
//  STARVE_MAX  4   cycles port 1 may wait (valid & !ready) before it is forced to win
//  CNT_W       16  width of statistics counters (RF_WB_STATS_EN only)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  srst        in   1       synchronous reset, active-high
//  wb0_valid   in   1       port 0 write request
//  wb0_rd      in   REG_AW  port 0 destination register
//  wb0_data    in   XLEN    port 0 write data
//  wb0_ready   out  1       port 0 accepted this cycle
//  wb1_valid   in   1       port 1 write request
//  wb1_rd      in   REG_AW  port 1 destination register
//  wb1_data    in   XLEN    port 1 write data
//  wb1_ready   out  1       port 1 accepted this cycle
//  rf_we       out  1       to register_file WE3 (registered)
//  rf_waddr    out  REG_AW  to register_file A3 (registered)
//  rf_wdata    out  XLEN    to register_file WD3 (registered)
//  stall_wb0   out  1       wb0_valid & !wb0_ready; hazard unit holds the pipeline
// BEHAVIOUR
//  - Handshake: transfer when valid & ready; valid/rd/data stable until accepted. ready is
//    combinational from valid + FSM state; at most one of wb0_ready/wb1_ready per cycle.
//  - FSM {NORMAL, FORCE1}. NORMAL: wb0 wins if valid, else wb1. FORCE1: wb1 wins if valid,
//    else wb0. starve_cnt increments each cycle wb1_valid & !wb1_ready, clears on wb1 accept
//    or !wb1_valid. NORMAL->FORCE1 when starve_cnt==STARVE_MAX-1 and wb1 loses again;
//    FORCE1->NORMAL after wb1 accepted or wb1_valid drops. Max wb1 wait = STARVE_MAX cycles.
//  - Latency 1: accept at posedge N -> rf_we/rf_waddr/rf_wdata valid for cycle N..N+1
//    (register_file commits at that cycle's negedge). No accept -> rf_we=0, addr/data hold.
//  - rd==0: request accepted normally (ready=1) but rf_we forced 0; x0 never written.
//  - Same rd on both ports same cycle: only winner written; loser written later (last write
//    wins in grant order). Ordering between ports is the scoreboard's job, not this block's.
//  - Back-to-back accepts allowed every cycle; full throughput 1 write/cycle.
//  - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, state=NORMAL, starve_cnt=0, both ready=0 in
//    the reset cycle; reset mid-request drops any in-flight accept (no write issued).
// CONFIGURATION
//  RF_WB_STATS_EN defined: adds outputs stat_conflicts (CNT_W, cycles both valid) and
//   stat_forced (CNT_W, grants made in FORCE1 over a valid wb0); saturating, cleared by srst.
//  Undefined: ports absent, no counter flops; arbitration identical.
// STRUCTURE
//  Package rf_wb_pkg: XLEN/REG_AW localparams, typedef wb_req_t {rd, data},
//   enum arb_state_e {NORMAL, FORCE1}.
//  Single module, no sub-module; starve counter and FSM inline, output register stage inline.
// TESTING
//  1 wb0 only: rd=5,data=0x5 at cycle 3 -> wb0_ready=1 @3, rf_we=1,waddr=5,wdata=5 @4.
//  2 wb1 only: rd=9,data=0x8 -> accepted same cycle, rf_we=1,waddr=9 next cycle.
//  3 both valid continuously, STARVE_MAX=4: wb0 wins 4 cycles, wb1 wins 5th, wb0 resumes;
//    stall_wb0=1 exactly in the 5th cycle.
//  4 rd=0,data=0xDEAD on wb0 -> wb0_ready=1, rf_we=0 next cycle; register 0 stays 0.
//  5 srst asserted while both valid -> no ready, rf_we=0 next cycle, FSM NORMAL, cnt 0.
//  6 RF_WB_STATS_EN: scenario 3 for 10 cycles -> stat_conflicts=10, stat_forced=2.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter: data/address widths,
// the writeback request record and the arbitration state encoding.
package rf_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the
// register file write port; master = sources/consumer side, slave = arbiter.
interface rf_wb_arbiter_if;
  import rf_wb_pkg::*;

  logic              wb0_valid;
  logic [REG_AW-1:0] wb0_rd;
  logic [XLEN-1:0]   wb0_data;
  logic              wb0_ready;
  logic              wb1_valid;
  logic [REG_AW-1:0] wb1_rd;
  logic [XLEN-1:0]   wb1_data;
  logic              wb1_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              stall_wb0;

  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  wb0_ready, wb1_ready, rf_we, rf_waddr, rf_wdata, stall_wb0
  );

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output wb0_ready, wb1_ready, rf_we, rf_waddr, rf_wdata, stall_wb0
  );

endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file write port arbiter: fixed priority to the pipeline WB
// port with starvation promotion of the long-latency port. RF_WB_STATS_EN adds counters.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            srst,
  rf_wb_arbiter_if.slave  wb
`ifdef RF_WB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_conflicts,
  output logic [CNT_W-1:0] stat_forced
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e        state_reg, state_next;
  logic [SW-1:0]     starve_cnt_reg, starve_cnt_next;
  wb_req_t           req0, req1, win_req;
  logic              grant0, grant1;
  logic              rf_we_reg;
  logic [REG_AW-1:0] rf_waddr_reg;
  logic [XLEN-1:0]   rf_wdata_reg;

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    req0   = '{rd: wb.wb0_rd, data: wb.wb0_data};
    req1   = '{rd: wb.wb1_rd, data: wb.wb1_data};
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!srst) begin
      if (state_reg == FORCE1) begin
        grant1 = wb.wb1_valid;
        grant0 = wb.wb0_valid & ~wb.wb1_valid;
      end else begin
        grant0 = wb.wb0_valid;
        grant1 = wb.wb1_valid & ~wb.wb0_valid;
      end
    end
    win_req = grant1 ? req1 : req0;
  end

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    if (wb.wb1_valid && !grant1) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
      if (state_reg == NORMAL && starve_cnt_reg == SW'(STARVE_MAX - 1))
        state_next = FORCE1;
    end else begin
      starve_cnt_next = '0;
      state_next      = NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg      <= NORMAL;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Output stage: x0 requests are consumed but never turned into a write.
  always_ff @(posedge clk) begin
    if (srst) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else if (grant0 || grant1) begin
      rf_we_reg    <= (win_req.rd != '0);
      rf_waddr_reg <= win_req.rd;
      rf_wdata_reg <= win_req.data;
    end else begin
      rf_we_reg    <= 1'b0;
    end
  end

  assign wb.wb0_ready = grant0;
  assign wb.wb1_ready = grant1;
  assign wb.stall_wb0 = wb.wb0_valid & ~grant0;
  assign wb.rf_we     = rf_we_reg;
  assign wb.rf_waddr  = rf_waddr_reg;
  assign wb.rf_wdata  = rf_wdata_reg;

`ifdef RF_WB_STATS_EN
  logic [CNT_W-1:0] stat_conflicts_reg, stat_forced_reg;

  // Forced grants count only when wb1 actually displaced a waiting wb0.
  always_ff @(posedge clk) begin
    if (srst) begin
      stat_conflicts_reg <= '0;
      stat_forced_reg    <= '0;
    end else begin
      if (wb.wb0_valid && wb.wb1_valid && stat_conflicts_reg != '1)
        stat_conflicts_reg <= stat_conflicts_reg + 1'b1;
      if (state_reg == FORCE1 && grant1 && wb.wb0_valid && stat_forced_reg != '1)
        stat_forced_reg <= stat_forced_reg + 1'b1;
    end
  end

  assign stat_conflicts = stat_conflicts_reg;
  assign stat_forced    = stat_forced_reg;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with a scoreboard of
// expected register-file writes. Define RF_WB_STATS_EN to also check the counters.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if bus ();

`ifdef RF_WB_STATS_EN
  logic [15:0] stat_conflicts, stat_forced;
`endif

  rf_wb_arbiter #(.STARVE_MAX(4), .CNT_W(16)) dut (
    .clk (clk),
    .srst(srst),
    .wb  (bus)
`ifdef RF_WB_STATS_EN
    ,
    .stat_conflicts(stat_conflicts),
    .stat_forced   (stat_forced)
`endif
  );

  typedef struct {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;
  logic [REG_AW-1:0] last_addr = '0;
  logic [XLEN-1:0]   last_data = '0;

  task automatic drive(input logic v0, input logic [REG_AW-1:0] rd0, input logic [XLEN-1:0] d0,
                       input logic v1, input logic [REG_AW-1:0] rd1, input logic [XLEN-1:0] d1);
    bus.wb0_valid = v0; bus.wb0_rd = rd0; bus.wb0_data = d0;
    bus.wb1_valid = v1; bus.wb1_rd = rd1; bus.wb1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // One clock: check grants mid-cycle, queue the expected write, check it after the edge.
  task automatic cycle(input logic e0, input logic e1, input string tag);
    exp_t e;
    logic exp_stall;
    @(negedge clk);
    exp_stall = bus.wb0_valid & ~e0;
    total++;
    if (bus.wb0_ready !== e0) $display("FAIL %s wb0_ready: got %b expected %b", tag, bus.wb0_ready, e0);
    else passed++;
    total++;
    if (bus.wb1_ready !== e1) $display("FAIL %s wb1_ready: got %b expected %b", tag, bus.wb1_ready, e1);
    else passed++;
    total++;
    if (bus.stall_wb0 !== exp_stall) $display("FAIL %s stall_wb0: got %b expected %b", tag, bus.stall_wb0, exp_stall);
    else passed++;
    if (srst) begin
      e = '{1'b0, '0, '0};
    end else if (e0) begin
      e = '{(bus.wb0_rd != '0), bus.wb0_rd, bus.wb0_data};
    end else if (e1) begin
      e = '{(bus.wb1_rd != '0), bus.wb1_rd, bus.wb1_data};
    end else begin
      e = '{1'b0, last_addr, last_data};
    end
    last_addr = e.addr;
    last_data = e.data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (bus.rf_we !== e.we) $display("FAIL %s rf_we: got %b expected %b", tag, bus.rf_we, e.we);
    else passed++;
    total++;
    if (bus.rf_waddr !== e.addr) $display("FAIL %s rf_waddr: got %0d expected %0d", tag, bus.rf_waddr, e.addr);
    else passed++;
    total++;
    if (bus.rf_wdata !== e.data) $display("FAIL %s rf_wdata: got %h expected %h", tag, bus.rf_wdata, e.data);
    else passed++;
    $display("[%0t] %s grant=%b%b rf_we=%b waddr=%0d wdata=%h", $time, tag, e0, e1,
             bus.rf_we, bus.rf_waddr, bus.rf_wdata);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    cycle(1'b0, 1'b0, "reset_a");
    cycle(1'b0, 1'b0, "reset_b");
    srst = 1'b0;
    idle();
    cycle(1'b0, 1'b0, "reset_idle");
  endtask

  task automatic test_wb0_only();
    idle();
    cycle(1'b0, 1'b0, "wb0_pre");
    drive(1'b1, 5'd5, 32'h5, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, "wb0_only");
    idle();
    cycle(1'b0, 1'b0, "wb0_hold");
  endtask

  task automatic test_wb1_only();
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h8);
    cycle(1'b0, 1'b1, "wb1_only");
    idle();
    cycle(1'b0, 1'b0, "wb1_hold");
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, "rd_zero");
    idle();
    cycle(1'b0, 1'b0, "rd_zero_after");
  endtask

  // Both ports valid on the same rd every cycle: wb1 must win every 5th cycle.
  task automatic test_starvation();
    logic [XLEN-1:0] d0, d1;
    logic e0;
    srst = 1'b1;
    idle();
    cycle(1'b0, 1'b0, "starve_rst");
    srst = 1'b0;
    d0 = 32'h100;
    d1 = 32'h200;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'd7, d0, 1'b1, 5'd7, d1);
      e0 = ((i % 5) != 4);
      cycle(e0, ~e0, $sformatf("starve_%0d", i));
      if (e0) d0 = d0 + 1;
      else    d1 = d1 + 1;
    end
`ifdef RF_WB_STATS_EN
    total++;
    if (stat_conflicts !== 16'd10) $display("FAIL stat_conflicts: got %0d expected 10", stat_conflicts);
    else passed++;
    total++;
    if (stat_forced !== 16'd2) $display("FAIL stat_forced: got %0d expected 2", stat_forced);
    else passed++;
`endif
    idle();
    cycle(1'b0, 1'b0, "starve_idle");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 1), $urandom, 1'b0, '0, '0);
      cycle(1'b1, 1'b0, $sformatf("b2b0_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        drive(1'b0, '0, '0, 1'b1, 5'(20 + i), $urandom);
        cycle(1'b0, 1'b1, $sformatf("b2b_alt_%0d", i));
      end else begin
        drive(1'b1, 5'(20 + i), $urandom, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, $sformatf("b2b_alt_%0d", i));
      end
    end
    idle();
    cycle(1'b0, 1'b0, "b2b_idle");
  endtask

  // Reset in the middle of a starvation run must drop the grant and clear the counter.
  task automatic test_reset_mid_request();
    drive(1'b1, 5'd11, 32'hB0B0, 1'b1, 5'd12, 32'hC0C0);
    cycle(1'b1, 1'b0, "mid_a");
    drive(1'b1, 5'd11, 32'hB0B1, 1'b1, 5'd12, 32'hC0C0);
    cycle(1'b1, 1'b0, "mid_b");
    srst = 1'b1;
    drive(1'b1, 5'd11, 32'hB0B2, 1'b1, 5'd12, 32'hC0C0);
    cycle(1'b0, 1'b0, "mid_rst");
    srst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd11, 32'hB0B2 + i, 1'b1, 5'd12, 32'hC0C0);
      cycle((i != 4), (i == 4), $sformatf("mid_post_%0d", i));
    end
    idle();
    cycle(1'b0, 1'b0, "mid_idle");
  endtask

  initial begin
    srst = 1'b1;
    idle();
    test_reset();
    test_wb0_only();
    test_wb1_only();
    test_rd_zero();
    test_starvation();
    test_back_to_back();
    test_reset_mid_request();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
